// File: rtl/frame_rd_req.sv
// Frame-buffer read requester: fetches one frame per fifo_rd_period falling edge in bursts,
// unpacks memory words into pixels and writes them into the output-stage pixel FIFO.
module frame_rd_req #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WIDTH  = 128,
    parameter int VID_WIDTH  = 16,
    parameter int BURST_LEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_en,
    input  logic                  fifo_rd_period,
    input  logic                  fifo_wr_almost_full,
    input  logic [12:0]           H_VALID,
    input  logic [12:0]           V_VALID,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic [7:0]            rd_req_len,
    input  logic                  rd_data_valid,
    output logic                  rd_data_ready,
    input  logic [MEM_WIDTH-1:0]  rd_data,
    output logic                  fifo_wr_en,
    output logic [VID_WIDTH-1:0]  fifo_wr_data,
    output logic                  frame_done,
    output logic                  frame_late
);

    // state    | meaning
    // IDLE     | waiting for a frame-start edge
    // REQ      | presenting the next burst request
    // DATA     | accepting beats of the outstanding burst
    // WAIT_PIX | all words fetched, unpacker finishing the last word
    // DRAIN    | discarding beats of an aborted burst

    localparam int PPW            = MEM_WIDTH / VID_WIDTH;
    localparam int SEL_W          = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int BYTES_PER_WORD = MEM_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_DATA, S_WAIT_PIX, S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic                  period_d;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [25:0]           total_pix;
    logic [25:0]           words_left;
    logic [25:0]           pix_cnt;
    logic [8:0]            beats_out;
    logic                  req_hold;
    logic                  pending_start;
    logic                  loaded;
    logic [MEM_WIDTH-1:0]  word_reg;
    logic [SEL_W-1:0]      pix_sel;

    logic [25:0] frame_pix_c;
    logic [26:0] pix_round;
    logic [25:0] words_c;
    logic [8:0]  burst_len;
    logic [8:0]  beats_nxt;
    logic        start_edge, done_now, last_pix, req_acc, beat_acc, wr_ok;
    state_t      start_state;

    assign frame_pix_c = 26'(H_VALID) * 26'(V_VALID);
    assign pix_round   = 27'(frame_pix_c) + 27'(PPW - 1);
    assign words_c     = 26'(pix_round / 27'(PPW));
    assign start_state = (words_c == 26'd0) ? S_WAIT_PIX : S_REQ;
    assign burst_len   = (words_left >= 26'(BURST_LEN)) ? 9'(BURST_LEN) : words_left[8:0];
    assign req_acc     = rd_req_valid & rd_req_ready;
    assign beat_acc    = rd_data_valid & rd_data_ready;
    assign beats_nxt   = req_acc ? burst_len : (beats_out - {8'd0, beat_acc});
    assign start_edge  = frame_en & period_d & ~fifo_rd_period;
    assign done_now    = (state == S_WAIT_PIX) & ~loaded;
    // A word ends at its last slot or at the frame's last pixel, so tail slots are never visited.
    assign last_pix    = loaded & ((pix_sel == SEL_W'(PPW - 1)) | (pix_cnt == total_pix - 26'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!frame_en) begin
            state_nxt = (beats_nxt != 9'd0) ? S_DRAIN : S_IDLE;
        end else if (start_edge) begin
            state_nxt = (beats_nxt != 9'd0) ? S_DRAIN : start_state;
        end else begin
            unique case (state)
                S_IDLE:     state_nxt = S_IDLE;
                S_REQ:      if (req_acc) state_nxt = S_DATA;
                S_DATA:     if (beat_acc && beats_out == 9'd1)
                                state_nxt = (words_left == 26'd0) ? S_WAIT_PIX : S_REQ;
                S_WAIT_PIX: if (!loaded) state_nxt = S_IDLE;
                S_DRAIN:    if (beats_nxt == 9'd0) begin
                                if (pending_start)
                                    state_nxt = (words_left == 26'd0) ? S_WAIT_PIX : S_REQ;
                                else
                                    state_nxt = S_IDLE;
                            end
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_d      <= 1'b0;
            cur_addr      <= '0;
            total_pix     <= '0;
            words_left    <= '0;
            beats_out     <= '0;
            req_hold      <= 1'b0;
            pending_start <= 1'b0;
            loaded        <= 1'b0;
            word_reg      <= '0;
            pix_sel       <= '0;
            pix_cnt       <= '0;
        end else begin
            period_d      <= fifo_rd_period;
            beats_out     <= beats_nxt;
            req_hold      <= rd_req_valid & ~rd_req_ready & ~start_edge;
            pending_start <= frame_en & (start_edge | (pending_start & (state == S_DRAIN)));
            if (start_edge) begin
                cur_addr   <= base_addr;
                total_pix  <= frame_pix_c;
                words_left <= words_c;
            end else if (req_acc) begin
                words_left <= words_left - 26'(burst_len);
                cur_addr   <= cur_addr + ADDR_WIDTH'(burst_len) * ADDR_WIDTH'(BYTES_PER_WORD);
            end
            if (!frame_en || start_edge) begin
                loaded  <= 1'b0;
                pix_sel <= '0;
                pix_cnt <= '0;
            end else begin
                if (loaded) begin
                    pix_cnt <= pix_cnt + 26'd1;
                    if (last_pix) begin
                        loaded  <= 1'b0;
                        pix_sel <= '0;
                    end else begin
                        pix_sel <= pix_sel + 1'b1;
                    end
                end
                if (beat_acc && state == S_DATA) begin
                    word_reg <= rd_data;
                    loaded   <= 1'b1;
                    pix_sel  <= '0;
                end
            end
        end
    end

    always_comb begin
        wr_ok         = frame_en & ~start_edge & loaded;
        rd_req_valid  = frame_en & (state == S_REQ) & (~fifo_wr_almost_full | req_hold);
        rd_req_addr   = rd_req_valid ? cur_addr : '0;
        rd_req_len    = rd_req_valid ? 8'(burst_len - 9'd1) : 8'd0;
        rd_data_ready = (state == S_DRAIN) |
                        (frame_en & (state == S_DATA) & (~loaded | last_pix));
        fifo_wr_en    = wr_ok;
        fifo_wr_data  = wr_ok ? word_reg[int'(pix_sel) * VID_WIDTH +: VID_WIDTH] : '0;
        frame_done    = frame_en & done_now;
        frame_late    = start_edge & (state != S_IDLE) & ~done_now;
    end

endmodule
